// File: rtl/cmprs_tile_mode_seq.sv
// cmprs_tile_mode_seq: frame-synchronised, multi-channel compressor tile-mode
// sequencer. Each channel holds a pending and an active (type, width_m1,
// height_m1) set. Pending settings move to active only on that channel's
// frame_start. A two-stage read pipeline returns decoded macroblock/tile
// geometry and macroblock column/row counts for a requested channel.
//
// Optional build macro: CMPRS_TILE_MODE_STATUS_EN adds the pending_st and
// applied status outputs. Core behaviour is the same with or without it.
//
// Handshake: rd_req is accepted on every cycle it is high; there is no
// backpressure. rd_valid is high for exactly one cycle per request, two
// cycles after the request. The geometry fields are meaningful only while
// rd_valid=1 and keep their last values while rd_valid=0.
module cmprs_tile_mode_seq #(
    parameter int         NUM_CHN       = 4,
    parameter int         CHN_BITS      = 2,
    parameter int         FRAME_BITS    = 13,
    parameter logic [2:0] CMPRS_COLOR18 = 3'd0,
    parameter logic [2:0] CMPRS_COLOR20 = 3'd1,
    parameter logic [2:0] CMPRS_MONO16  = 3'd2,
    parameter logic [2:0] CMPRS_JP4     = 3'd3,
    parameter logic [2:0] CMPRS_JP4DIFF = 3'd4,
    parameter logic [2:0] CMPRS_MONO8   = 3'd7
) (
    input  logic                  mclk,
    input  logic                  mrst_n,
    input  logic                  set_mode,
    input  logic [CHN_BITS-1:0]   set_chn,
    input  logic [2:0]            set_type,
    input  logic [FRAME_BITS-1:0] set_width_m1,
    input  logic [FRAME_BITS-1:0] set_height_m1,
    input  logic [NUM_CHN-1:0]    frame_start,
    input  logic                  rd_req,
    input  logic [CHN_BITS-1:0]   rd_chn,
    output logic                  rd_valid,
    output logic [5:0]            mb_w_m1,
    output logic [5:0]            mb_h_m1,
    output logic [4:0]            mb_hper,
    output logic [1:0]            tile_width,
    output logic                  tile_col_width,
    output logic [FRAME_BITS-1:0] mb_cols_m1,
    output logic [FRAME_BITS-1:0] mb_rows_m1,
    output logic                  cmd_err
`ifdef CMPRS_TILE_MODE_STATUS_EN
    ,
    output logic [NUM_CHN-1:0]    pending_st,
    output logic [NUM_CHN-1:0]    applied
`endif
);

    // Per-channel pending (written by control) and active (used by readers) sets.
    logic [NUM_CHN-1:0]    pending;
    logic [2:0]            pend_type [NUM_CHN];
    logic [FRAME_BITS-1:0] pend_w    [NUM_CHN];
    logic [FRAME_BITS-1:0] pend_h    [NUM_CHN];
    logic [2:0]            act_type  [NUM_CHN];
    logic [FRAME_BITS-1:0] act_w     [NUM_CHN];
    logic [FRAME_BITS-1:0] act_h     [NUM_CHN];

    logic type_ok;
    logic set_chn_ok;
    logic rd_chn_ok;

    // Read pipeline stage 1 holds a snapshot of the requested channel's active set.
    logic                  s1_valid;
    logic [2:0]            s1_type;
    logic [FRAME_BITS-1:0] s1_w;
    logic [FRAME_BITS-1:0] s1_h;

    // Decoded geometry for the stage 1 snapshot.
    logic [5:0]            dec_w_m1;
    logic [5:0]            dec_h_m1;
    logic [4:0]            dec_hper;
    logic [1:0]            dec_tile_width;
    logic                  dec_col_width;
    logic                  dec_mb8;
    logic [FRAME_BITS-1:0] dec_cols_m1;
    logic [FRAME_BITS-1:0] dec_rows_m1;

    // Out-of-range channel indices only exist when NUM_CHN is not a power of two.
    assign set_chn_ok = ({1'b0, set_chn} < (CHN_BITS+1)'(NUM_CHN));
    assign rd_chn_ok  = ({1'b0, rd_chn}  < (CHN_BITS+1)'(NUM_CHN));

    // Classify the written converter type as supported or not.
    always_comb begin
        type_ok = 1'b0;
        case (set_type)
            CMPRS_COLOR18, CMPRS_COLOR20, CMPRS_MONO16,
            CMPRS_JP4, CMPRS_JP4DIFF, CMPRS_MONO8: type_ok = 1'b1;
            default:                               type_ok = 1'b0;
        endcase
    end

    // Pending writes and frame-start apply. The apply reads the pending set from
    // before this edge, so a same-cycle write becomes the next pending value.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_CHN; i++) begin
                pend_type[i] <= CMPRS_COLOR18;
                pend_w[i]    <= '0;
                pend_h[i]    <= '0;
                act_type[i]  <= CMPRS_COLOR18;
                act_w[i]     <= '0;
                act_h[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHN; i++) begin
                if (frame_start[i] && pending[i]) begin
                    act_type[i] <= pend_type[i];
                    act_w[i]    <= pend_w[i];
                    act_h[i]    <= pend_h[i];
                    pending[i]  <= 1'b0;
                end
                if (set_mode && set_chn_ok && type_ok && (set_chn == CHN_BITS'(i))) begin
                    pend_type[i] <= set_type;
                    pend_w[i]    <= set_width_m1;
                    pend_h[i]    <= set_height_m1;
                    pending[i]   <= 1'b1;
                end
            end
        end
    end

    // Sticky error: set by an unsupported type, cleared by the next supported write.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            cmd_err <= 1'b0;
        end else if (set_mode && set_chn_ok) begin
            cmd_err <= !type_ok;
        end
    end

    // Stage 1: capture the active set of rd_chn as it was before this edge.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            s1_valid <= 1'b0;
            s1_type  <= CMPRS_COLOR18;
            s1_w     <= '0;
            s1_h     <= '0;
        end else begin
            s1_valid <= rd_req;
            if (rd_req) begin
                if (rd_chn_ok) begin
                    s1_type <= act_type[rd_chn];
                    s1_w    <= act_w[rd_chn];
                    s1_h    <= act_h[rd_chn];
                end else begin
                    s1_type <= CMPRS_COLOR18;
                    s1_w    <= '0;
                    s1_h    <= '0;
                end
            end
        end
    end

    // Decode converter type into macroblock/tile geometry; counts use the period only.
    always_comb begin
        dec_w_m1       = 6'd17;
        dec_h_m1       = 6'd17;
        dec_hper       = 5'd16;
        dec_tile_width = 2'd1;
        dec_col_width  = 1'b1;
        dec_mb8        = 1'b0;
        case (s1_type)
            CMPRS_COLOR20: begin
                dec_w_m1 = 6'd19;
                dec_h_m1 = 6'd19;
            end
            CMPRS_MONO16, CMPRS_JP4, CMPRS_JP4DIFF: begin
                dec_w_m1       = 6'd15;
                dec_h_m1       = 6'd15;
                dec_tile_width = 2'd2;
            end
            CMPRS_MONO8: begin
                dec_w_m1       = 6'd7;
                dec_h_m1       = 6'd7;
                dec_hper       = 5'd8;
                dec_tile_width = 2'd3;
                dec_mb8        = 1'b1;
            end
            default: ;
        endcase
        dec_cols_m1 = dec_mb8 ? (s1_w >> 3) : (s1_w >> 4);
        dec_rows_m1 = dec_mb8 ? (s1_h >> 3) : (s1_h >> 4);
    end

    // Stage 2: register decoded outputs; they hold while no result is presented.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            rd_valid       <= 1'b0;
            mb_w_m1        <= '0;
            mb_h_m1        <= '0;
            mb_hper        <= '0;
            tile_width     <= '0;
            tile_col_width <= 1'b0;
            mb_cols_m1     <= '0;
            mb_rows_m1     <= '0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
                mb_w_m1        <= dec_w_m1;
                mb_h_m1        <= dec_h_m1;
                mb_hper        <= dec_hper;
                tile_width     <= dec_tile_width;
                tile_col_width <= dec_col_width;
                mb_cols_m1     <= dec_cols_m1;
                mb_rows_m1     <= dec_rows_m1;
            end
        end
    end

`ifdef CMPRS_TILE_MODE_STATUS_EN
    assign pending_st = pending;

    // One-cycle pulse on the clock after a channel applies its pending set.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            applied <= '0;
        end else begin
            applied <= frame_start & pending;
        end
    end
`endif

endmodule

// File: tb/tb_cmprs_tile_mode_seq.sv
// Directed bench for cmprs_tile_mode_seq: stimulus pushes hand-computed
// results into an expected queue, a negedge monitor pops and compares
// whenever rd_valid is high, and checks latency and output hold.
module tb_cmprs_tile_mode_seq;
    localparam int NUM_CHN    = 4;
    localparam int CHN_BITS   = 2;
    localparam int FRAME_BITS = 13;
    localparam int W          = 46;

    logic                  mclk;
    logic                  mrst_n;
    logic                  set_mode;
    logic [CHN_BITS-1:0]   set_chn;
    logic [2:0]            set_type;
    logic [FRAME_BITS-1:0] set_width_m1;
    logic [FRAME_BITS-1:0] set_height_m1;
    logic [NUM_CHN-1:0]    frame_start;
    logic                  rd_req;
    logic [CHN_BITS-1:0]   rd_chn;
    logic                  rd_valid;
    logic [5:0]            mb_w_m1;
    logic [5:0]            mb_h_m1;
    logic [4:0]            mb_hper;
    logic [1:0]            tile_width;
    logic                  tile_col_width;
    logic [FRAME_BITS-1:0] mb_cols_m1;
    logic [FRAME_BITS-1:0] mb_rows_m1;
    logic                  cmd_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    cmprs_tile_mode_seq dut (
        .mclk           (mclk),
        .mrst_n         (mrst_n),
        .set_mode       (set_mode),
        .set_chn        (set_chn),
        .set_type       (set_type),
        .set_width_m1   (set_width_m1),
        .set_height_m1  (set_height_m1),
        .frame_start    (frame_start),
        .rd_req         (rd_req),
        .rd_chn         (rd_chn),
        .rd_valid       (rd_valid),
        .mb_w_m1        (mb_w_m1),
        .mb_h_m1        (mb_h_m1),
        .mb_hper        (mb_hper),
        .tile_width     (tile_width),
        .tile_col_width (tile_col_width),
        .mb_cols_m1     (mb_cols_m1),
        .mb_rows_m1     (mb_rows_m1),
        .cmd_err        (cmd_err)
    );

    // clock / cycle counter
    initial mclk = 1'b0;
    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pack(input int w, input int h, input int hper,
                                          input int tw, input int tcw,
                                          input int cols, input int rows);
        logic [5:0]  w6   = w[5:0];
        logic [5:0]  h6   = h[5:0];
        logic [4:0]  p5   = hper[4:0];
        logic [1:0]  tw2  = tw[1:0];
        logic        tc1  = tcw[0];
        logic [12:0] c13  = cols[12:0];
        logic [12:0] r13  = rows[12:0];
        return {w6, h6, p5, tw2, tc1, c13, r13};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks: each holds its strobe across exactly one rising edge
    task automatic do_write(input int chn, input int typ, input int w, input int h,
                            input logic [NUM_CHN-1:0] fs);
        @(negedge mclk);
        set_mode      = 1'b1;
        set_chn       = chn[CHN_BITS-1:0];
        set_type      = typ[2:0];
        set_width_m1  = w[FRAME_BITS-1:0];
        set_height_m1 = h[FRAME_BITS-1:0];
        frame_start   = fs;
        @(posedge mclk);
        #1;
        set_mode    = 1'b0;
        frame_start = '0;
    endtask

    task automatic do_fs(input int chn);
        @(negedge mclk);
        frame_start      = '0;
        frame_start[chn] = 1'b1;
        @(posedge mclk);
        #1;
        frame_start = '0;
    endtask

    task automatic do_read(input int chn, input int w, input int h, input int hper,
                           input int tw, input int tcw, input int cols, input int rows);
        @(negedge mclk);
        rd_req = 1'b1;
        rd_chn = chn[CHN_BITS-1:0];
        exp_q.push_back(pack(w, h, hper, tw, tcw, cols, rows));
        exp_cyc_q.push_back(cyc + 2);
        @(posedge mclk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic check_cmd_err(input string name, input logic exp);
        @(negedge mclk);
        check(name, W'(cmd_err), W'(exp));
    endtask

    // scoreboard monitor
    logic [W-1:0] got;
    logic [W-1:0] last;
    bit           have_last = 0;
    always @(negedge mclk) begin
        got = {mb_w_m1, mb_h_m1, mb_hper, tile_width, tile_col_width, mb_cols_m1, mb_rows_m1};
        if (!mrst_n) begin
            have_last = 0;
        end else if (rd_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got rd_valid=1 at cycle %0d expected no result", cyc);
            end else begin
                logic [W-1:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("read_data", got, e);
                check("read_latency", W'(cyc), W'(ec));
                last      = e;
                have_last = 1;
            end
        end else begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_valid: got rd_valid=0 at cycle %0d expected result due at %0d",
                         cyc, exp_cyc_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (have_last) check("output_hold", got, last);
        end
    end

    // stimulus
    initial begin
        mrst_n        = 1'b0;
        set_mode      = 1'b0;
        set_chn       = '0;
        set_type      = '0;
        set_width_m1  = '0;
        set_height_m1 = '0;
        frame_start   = '0;
        rd_req        = 1'b0;
        rd_chn        = '0;
        repeat (3) @(negedge mclk);
        mrst_n = 1'b1;

        // reset state
        @(negedge mclk);
        check("reset_rd_valid", W'(rd_valid), W'(0));
        check("reset_outputs",
              {mb_w_m1, mb_h_m1, mb_hper, tile_width, tile_col_width, mb_cols_m1, mb_rows_m1}, '0);
        check("reset_cmd_err", W'(cmd_err), W'(0));
        do_read(0, 17, 17, 16, 1, 1, 0, 0);

        // chn1: JP4 pending, not visible until frame_start
        do_write(1, 3, 2591, 1935, '0);
        do_read(1, 17, 17, 16, 1, 1, 0, 0);
        do_fs(1);
        do_read(1, 15, 15, 16, 2, 1, 161, 120);

        // chn2: MONO8
        do_write(2, 7, 639, 479, '0);
        do_fs(2);
        do_read(2, 7, 7, 8, 3, 1, 79, 59);

        // chn0: unsupported type discarded, sticky error, cleared by good write
        do_write(0, 5, 100, 100, '0);
        check_cmd_err("cmd_err_set_type5", 1'b1);
        do_fs(0);
        do_read(0, 17, 17, 16, 1, 1, 0, 0);
        do_write(0, 1, 319, 239, '0);
        check_cmd_err("cmd_err_cleared", 1'b0);
        do_fs(0);
        do_read(0, 19, 19, 16, 1, 1, 19, 14);

        // chn3: apply JP4DIFF, then write+frame_start collision
        do_write(3, 4, 511, 511, '0);
        do_fs(3);
        do_read(3, 15, 15, 16, 2, 1, 31, 31);
        do_write(3, 2, 1023, 767, '0);
        do_write(3, 7, 255, 127, 4'b1000);
        do_read(3, 15, 15, 16, 2, 1, 63, 47);
        do_fs(3);
        do_read(3, 7, 7, 8, 3, 1, 31, 15);

        // back-to-back reads of all channels
        do_read(0, 19, 19, 16, 1, 1, 19, 14);
        do_read(1, 15, 15, 16, 2, 1, 161, 120);
        do_read(2, 7, 7, 8, 3, 1, 79, 59);
        do_read(3, 7, 7, 8, 3, 1, 31, 15);
        repeat (4) @(negedge mclk);

        // type 6 is unsupported too
        do_write(1, 6, 5, 5, '0);
        check_cmd_err("cmd_err_set_type6", 1'b1);

        // reset mid-stream: both in-flight results dropped
        do_read(0, 19, 19, 16, 1, 1, 19, 14);
        do_read(1, 15, 15, 16, 2, 1, 161, 120);
        #1;
        mrst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge mclk);
        check("midreset_rd_valid", W'(rd_valid), W'(0));
        repeat (2) @(negedge mclk);
        mrst_n = 1'b1;
        @(negedge mclk);
        check("post_reset_rd_valid", W'(rd_valid), W'(0));
        check("post_reset_cmd_err", W'(cmd_err), W'(0));
        for (int c = 0; c < NUM_CHN; c++) do_read(c, 17, 17, 16, 1, 1, 0, 0);

        // drain with a bounded wait
        for (int i = 0; i < 20; i++) begin
            @(negedge mclk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmprs_tile_mode_seq.md
Name: cmprs_tile_mode_seq

Overview:
Multi-channel, frame-synchronised successor to the combinational compressor tile-mode decoder. Holds per-channel pending and active compressor mode plus frame size. Applies pending settings only at that channel's frame start. Serves pipelined read requests that return the decoded macroblock/tile geometry and macroblock column/row counts. Sits between the compressor control register interface and the per-channel tile/macroblock address generators.

Parameters:
NUM_CHN, 4, number of compressor channels
CHN_BITS, 2, channel index width; must satisfy 2**CHN_BITS >= NUM_CHN
FRAME_BITS, 13, width of the frame width/height fields (pixels minus 1)
CMPRS_COLOR18, 0, converter code: 18x18 overlapping tiles
CMPRS_COLOR20, 1, converter code: 20x20 overlapping tiles (implemented here)
CMPRS_MONO16, 2, converter code: 16x16 mono
CMPRS_JP4, 3, converter code: JP4 16x16
CMPRS_JP4DIFF, 4, converter code: JP4 differential 16x16
CMPRS_MONO8, 7, converter code: 8x8 mono

Ports:
mclk  input  1  system clock
mrst_n  input  1  asynchronous active-low reset
set_mode  input  1  one-cycle write strobe
set_chn  input  CHN_BITS  channel being written
set_type  input  3  converter type
set_width_m1  input  FRAME_BITS  frame width in pixels minus 1
set_height_m1  input  FRAME_BITS  frame height in pixels minus 1
frame_start  input  NUM_CHN  per-channel frame start strobes
rd_req  input  1  read request strobe
rd_chn  input  CHN_BITS  channel to read
rd_valid  output  1  read result valid
mb_w_m1  output  6  macroblock width minus 1
mb_h_m1  output  6  macroblock height minus 1
mb_hper  output  5  macroblock horizontal period
tile_width  output  2  memory tile width code (0:16, 1:32, 2:64, 3:128)
tile_col_width  output  1  0: 16-pixel columns, 1: 32-pixel columns
mb_cols_m1  output  FRAME_BITS  macroblock columns minus 1
mb_rows_m1  output  FRAME_BITS  macroblock rows minus 1
cmd_err  output  1  sticky flag: an unsupported set_type was written

Behaviour:
- Reset (async, mrst_n=0) clears all of the following:
  - all per-channel pending flags;
  - active type set to CMPRS_COLOR18, active width_m1 and height_m1 set to 0;
  - rd_valid, cmd_err and all geometry outputs set to 0.
- Write, set_mode=1:
  - Supported type (one of the six codes): store type, width_m1 and height_m1 in channel set_chn's pending registers and set its pending flag. Each later write overwrites the previous one.
  - Unsupported type (5 or 6): discard the write (pending registers and flag unchanged) and set cmd_err. A later write with a supported type clears cmd_err.
  - set_chn >= NUM_CHN: ignore the write.
- Apply: on frame_start[i] with pending[i]=1, copy pending to active on the same edge and clear pending[i]. frame_start with no pending value does nothing.
- Write and frame_start to the same channel in the same cycle: the old pending value is applied. The new write becomes pending and the flag stays 1.
- Read pipeline, latency 2, throughput 1 per cycle:
  - Stage 1 registers the active type/size of rd_chn.
  - Stage 2 decodes and registers the outputs; rd_valid=1 exactly 2 cycles after rd_req.
  - Back-to-back requests give back-to-back results.
  - Outputs hold their values while rd_valid=0.
  - A read sees active values as of the cycle of rd_req. An apply in that same cycle is not visible.
- Decode table (mb_w_m1 / mb_h_m1 / mb_hper / tile_width / tile_col_width):
  - COLOR18: 17 / 17 / 16 / 1 / 1
  - COLOR20: 19 / 19 / 16 / 1 / 1
  - MONO16, JP4, JP4DIFF: 15 / 15 / 16 / 2 / 1
  - MONO8: 7 / 7 / 8 / 3 / 1
- Counts:
  - hper=16: mb_cols_m1 = width_m1>>4 and mb_rows_m1 = height_m1>>4, zero-extended.
  - hper=8: mb_cols_m1 = width_m1>>3 and mb_rows_m1 = height_m1>>3, zero-extended.
  - Overlap does not affect counts.
- Reset mid-read: the in-flight result is dropped and rd_valid is 0 after release.

Optional Feature:
CMPRS_TILE_MODE_STATUS_EN:
- Defined: adds output pending_st[NUM_CHN-1:0], which mirrors the pending flags, and output applied[NUM_CHN-1:0], which pulses for one cycle the clock after an apply on that channel. Both reset to 0.
- Undefined: these ports are absent. Core behaviour is identical.

Test Plan:
- Reset then rd_req, rd_chn=0 -> rd_valid at +2 with 17/17/16/1/1, mb_cols_m1=0, mb_rows_m1=0, cmd_err=0.
- Write chn1 type=3, width_m1=2591, height_m1=1935; read chn1 before frame_start -> COLOR18 values. Then frame_start[1] and read again -> 15/15/16/2/1, cols_m1=161, rows_m1=120.
- Write chn2 type=7, width_m1=639, height_m1=479; frame_start[2]; read -> 7/7/8/3/1, cols_m1=79, rows_m1=59.
- Write type=5 to chn0 -> cmd_err=1, chn0 unchanged after frame_start. Then write type=1 -> cmd_err=0.
- Write chn3 type=2, apply; in one cycle write chn3 type=7 with frame_start[3] -> read gives MONO16, pending stays set; next frame_start[3] -> MONO8.
- Four back-to-back rd_req for chn0..3 -> four consecutive rd_valid cycles, results in order. Assert mrst_n mid-stream -> rd_valid=0 and all channels revert to COLOR18.
